axi2mem_tcdm_rd_chan: RTL and testbench

AXI2MEM_TCDM_RD_CHAN -- requirements
Module: axi2mem_tcdm_rd_chan

---
 rtl/axi2mem_pkg.sv | 12 +
 rtl/axi2mem_rd_fifo.sv | 35 +++
 rtl/axi2mem_tcdm_rd_chan.sv | 104 ++++++++++
 tb/tb_axi2mem_tcdm_rd_chan.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/axi2mem_pkg.sv
// axi2mem_pkg: default parameters and the read-command record shared by the TCDM read channel.
package axi2mem_pkg;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_ID_WIDTH   = 6;
    localparam int unsigned DEF_MAX_OUTST  = 4;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0] id;
        logic                    last;
    } rd_cmd_t;
endpackage

// File: rtl/axi2mem_rd_fifo.sv
// axi2mem_rd_fifo: power-of-two depth FIFO with first-word-fall-through output.
module axi2mem_rd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
            if (pop_i)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rd_q[AW-1:0]];
    assign empty_o = wr_q == rd_q;
endmodule

// File: rtl/axi2mem_tcdm_rd_chan.sv
// axi2mem_tcdm_rd_chan: credit-limited read channel from command port to TCDM and back.
// Define AXI2MEM_RD_BYPASS_EN to forward a response straight to the data port when the buffer is empty.
module axi2mem_tcdm_rd_chan
    import axi2mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH,
    parameter int unsigned MAX_OUTST  = DEF_MAX_OUTST
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    trans_req_i,
    output logic                    trans_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   trans_add_i,
    input  logic [ID_WIDTH-1:0]     trans_id_i,
    input  logic                    trans_last_i,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    output logic [DATA_WIDTH-1:0]   data_dat_o,
    output logic [ID_WIDTH-1:0]     data_id_o,
    output logic                    data_last_o,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
    output logic                    tcdm_we_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    output logic [DATA_WIDTH-1:0]   tcdm_wdata_o,
    input  logic [DATA_WIDTH-1:0]   tcdm_r_rdata_i,
    input  logic                    tcdm_r_valid_i,
    output logic                    err_o
);
    localparam int unsigned CW = $clog2(MAX_OUTST) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

    logic [CW-1:0]         cnt_q, cnt_d, pend_q, pend_d;
    logic                  err_q, err_d;
    logic                  data_hs, rsp_ok, rsp_push, byp;
    logic                  cmd_empty, rsp_empty;
    logic [ID_WIDTH:0]     cmd_head;
    logic [DATA_WIDTH-1:0] rsp_head;

    assign tcdm_req_o   = trans_req_i && (cnt_q < MAX_CNT) && !rst_i;
    assign trans_gnt_o  = tcdm_req_o && tcdm_gnt_i;
    assign tcdm_add_o   = trans_add_i;
    assign tcdm_we_o    = 1'b1;
    assign tcdm_be_o    = '1;
    assign tcdm_wdata_o = '0;

    // pend_q counts granted reads still waiting for memory data; anything beyond it is spurious
    assign rsp_ok = tcdm_r_valid_i && (pend_q != '0);

`ifdef AXI2MEM_RD_BYPASS_EN
    assign byp = rsp_empty && rsp_ok;
`else
    assign byp = 1'b0;
`endif

    assign data_req_o  = (!rsp_empty || byp) && !cmd_empty;
    assign data_hs     = data_req_o && data_gnt_i;
    assign data_dat_o  = byp ? tcdm_r_rdata_i : rsp_head;
    assign data_id_o   = cmd_head[ID_WIDTH:1];
    assign data_last_o = cmd_head[0];
    assign rsp_push    = rsp_ok && !(byp && data_gnt_i);
    assign err_o       = err_q;

    always_comb begin
        cnt_d  = cnt_q + CW'(trans_gnt_o) - CW'(data_hs);
        pend_d = pend_q + CW'(trans_gnt_o) - CW'(rsp_ok);
        err_d  = err_q || (tcdm_r_valid_i && !rsp_ok);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    axi2mem_rd_fifo #(.WIDTH(ID_WIDTH + 1), .DEPTH(MAX_OUTST)) i_cmd_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (trans_gnt_o),
        .pop_i   (data_hs),
        .data_i  ({trans_id_i, trans_last_i}),
        .data_o  (cmd_head),
        .empty_o (cmd_empty)
    );

    axi2mem_rd_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_OUTST)) i_rsp_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rsp_push),
        .pop_i   (data_hs && !rsp_empty),
        .data_i  (tcdm_r_rdata_i),
        .data_o  (rsp_head),
        .empty_o (rsp_empty)
    );
endmodule

// File: tb/tb_axi2mem_tcdm_rd_chan.sv
// tb_axi2mem_tcdm_rd_chan: directed and random checks of the read channel against a queue-based model.
module tb_axi2mem_tcdm_rd_chan;
`ifdef AXI2MEM_RD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAXO = 4;

    typedef struct {
        logic [5:0]  id;
        logic        last;
        logic [31:0] dat;
    } beat_t;

    logic        clk = 0, rst_i = 1;
    logic        trans_req_i = 0, trans_gnt_o, trans_last_i = 0;
    logic [31:0] trans_add_i = 0, tcdm_add_o;
    logic [5:0]  trans_id_i = 0, data_id_o;
    logic        data_req_o, data_gnt_i = 0, data_last_o;
    logic [31:0] data_dat_o, tcdm_wdata_o, tcdm_r_rdata_i = 0;
    logic        tcdm_req_o, tcdm_gnt_i = 0, tcdm_we_o, tcdm_r_valid_i = 0, err_o;
    logic [3:0]  tcdm_be_o;

    int    n_cmp = 0, n_bad = 0;
    int    cnt = 0, pend = 0;
    bit    eerr = 0;
    beat_t cmdq[$];
    logic [31:0] respq[$];
    beat_t blog[$];
    bit    obs_req, obs_gnt, obs_beat, obs_treq;

    always #5 clk = ~clk;

    axi2mem_tcdm_rd_chan dut (
        .clk_i(clk), .rst_i(rst_i),
        .trans_req_i(trans_req_i), .trans_gnt_o(trans_gnt_o), .trans_add_i(trans_add_i),
        .trans_id_i(trans_id_i), .trans_last_i(trans_last_i),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_dat_o(data_dat_o),
        .data_id_o(data_id_o), .data_last_o(data_last_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_we_o(tcdm_we_o), .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o),
        .tcdm_r_rdata_i(tcdm_r_rdata_i), .tcdm_r_valid_i(tcdm_r_valid_i), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rst_seq();
        @(negedge clk);
        rst_i = 1; trans_req_i = 1; tcdm_gnt_i = 1; data_gnt_i = 0; tcdm_r_valid_i = 0;
        #1;
        chk("rst_tcdm_req", tcdm_req_o, 0);
        chk("rst_trans_gnt", trans_gnt_o, 0);
        chk("rst_data_req", data_req_o, 0);
        chk("rst_err", err_o, 0);
        @(negedge clk);
        rst_i = 0; trans_req_i = 0; tcdm_gnt_i = 0;
        cnt = 0; pend = 0; eerr = 0;
        cmdq.delete(); respq.delete();
    endtask

    task automatic step(input bit treq, input bit tg, input bit dg, input bit rv,
                        input logic [5:0] id, input bit lst, input logic [31:0] rd);
        bit ereq, egnt, eout;
        logic [31:0] ad, ed;
        @(negedge clk);
        ad = $urandom;
        trans_req_i = treq; tcdm_gnt_i = tg; trans_add_i = ad; trans_id_i = id; trans_last_i = lst;
        data_gnt_i = dg; tcdm_r_valid_i = rv; tcdm_r_rdata_i = rd;
        #1;
        ereq = treq && cnt < MAXO;
        egnt = ereq && tg;
        eout = respq.size() > 0 || (BYP && rv && pend > 0);
        chk("tcdm_req", tcdm_req_o, ereq);
        chk("trans_gnt", trans_gnt_o, egnt);
        chk("tcdm_add", tcdm_add_o, ad);
        chk("tcdm_fixed", {tcdm_we_o, tcdm_be_o, tcdm_wdata_o}, {1'b1, 4'hF, 32'h0});
        chk("data_req", data_req_o, eout);
        chk("err", err_o, eerr);
        if (eout && cmdq.size() > 0) begin
            ed = respq.size() > 0 ? respq[0] : rd;
            chk("data_dat", data_dat_o, ed);
            chk("data_id", data_id_o, cmdq[0].id);
            chk("data_last", data_last_o, cmdq[0].last);
        end
        obs_req = data_req_o; obs_gnt = trans_gnt_o; obs_treq = tcdm_req_o;
        obs_beat = data_req_o && dg;
        if (obs_beat) blog.push_back('{data_id_o, data_last_o, data_dat_o});
        if (rv) begin
            if (pend > 0) begin pend--; respq.push_back(rd); end
            else eerr = 1;
        end
        if (egnt) begin cmdq.push_back('{id, lst, 32'h0}); pend++; cnt++; end
        if (eout && dg) begin void'(respq.pop_front()); void'(cmdq.pop_front()); cnt--; end
    endtask

    initial begin
        int n;
        rst_seq();
        // credit limit with the data port stalled
        n = 0;
        for (int i = 0; i < 6; i++) begin step(1, 1, 0, 0, 6'(i), 0, 0); n += int'(obs_gnt); end
        chk("credit_gnts", n, MAXO);
        chk("credit_stall", obs_treq, 0);
        // four responses while stalled for ten cycles, then four consecutive beats
        for (int i = 0; i < 10; i++) step(1, 1, 0, i < 4, 0, 0, $urandom);
        for (int i = 0; i < 4; i++) begin step(0, 0, 1, 0, 0, 0, 0); chk("drain_beat", obs_beat, 1); end
        step(1, 0, 1, 0, 0, 0, 0);
        chk("drain_req", obs_treq, 1);
        // ordered delivery with id/last
        rst_seq();
        blog.delete();
        step(1, 1, 1, 0, 6'h05, 0, 0);
        step(1, 1, 1, 0, 6'h06, 1, 0);
        step(0, 0, 1, 1, 0, 0, 32'hA5A5A5A5);
        chk("lat_req", obs_req, BYP);
        step(0, 0, 1, 1, 0, 0, 32'h5A5A5A5A);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("order_n", blog.size(), 2);
        if (blog.size() == 2) begin
            chk("order0", {blog[0].id, blog[0].last, blog[0].dat}, {6'h05, 1'b0, 32'hA5A5A5A5});
            chk("order1", {blog[1].id, blog[1].last, blog[1].dat}, {6'h06, 1'b1, 32'h5A5A5A5A});
        end
        // spurious response
        rst_seq();
        step(0, 0, 1, 1, 0, 0, 32'h1234);
        chk("spur_req", obs_req, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        chk("spur_err_held", err_o, 1);
        // reset with reads in flight
        rst_seq();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 6'(i), 0, 0);
        rst_seq();
        step(0, 0, 1, 1, 0, 0, 32'hDEAD);
        step(1, 1, 1, 0, 6'h11, 1, 0);
        chk("post_rst_gnt", obs_gnt, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("post_rst_err", err_o, 1);
        // random traffic
        rst_seq();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                 pend > 0 && $urandom_range(0, 99) < 60, 6'($urandom), 1'($urandom), $urandom);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
